// File: rtl/alu_multicycle_pkg.sv
// ALU control codes shared by the ALU control decoder and the multi-cycle execution unit.
package alu_multicycle_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_SRA  = 3'b110;
  localparam logic [2:0] ALU_RSVD = 3'b111;

endpackage

// File: rtl/alu_multicycle_mul_shift_add.sv
// Iterative shift-add multiplier with fixed WIDTH-step latency; o_product is valid while o_done is high.
module mul_shift_add #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [SHW-1:0]   r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // Product includes the final step so the result can be latched on the last MUL_RUN edge.
  assign o_product  = w_acc_next;
  assign o_done     = r_busy && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= SHW'(WIDTH - 1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - SHW'(1);
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MUL, valid/ready on both sides.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MUL_RUN = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]              r_state;
  logic [WIDTH-1:0]        r_data;
  logic [WIDTH-1:0]        w_alu;
  logic [SHW-1:0]          w_shamt;
  logic signed [WIDTH-1:0] w_a_signed;
  logic                    w_accept;
  logic                    w_mul_start;
  logic                    w_mul_done;
  logic [WIDTH-1:0]        w_mul_product;

  assign ready_o     = (r_state == S_IDLE);
  assign valid_o     = (r_state == S_DONE);
  assign data_o      = r_data;
  assign zero_o      = (r_data == '0);
  assign w_accept    = valid_i && ready_o;
  assign w_mul_start = w_accept && (ALUCtrl_i == ALU_MUL);
  assign w_shamt     = data2_i[SHW-1:0];
  assign w_a_signed  = data1_i;

  always_comb begin
    w_alu = '0;
    case (ALUCtrl_i)
      ALU_AND: w_alu = data1_i & data2_i;
      ALU_XOR: w_alu = data1_i ^ data2_i;
      ALU_SLL: w_alu = data1_i << w_shamt;
      ALU_ADD: w_alu = data1_i + data2_i;
      ALU_SUB: w_alu = data1_i - data2_i;
      ALU_SRA: w_alu = w_a_signed >>> w_shamt;
      default: w_alu = '0;
    endcase
  end

  mul_shift_add #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_start   (w_mul_start),
    .i_a       (data1_i),
    .i_b       (data2_i),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (ALUCtrl_i == ALU_MUL) begin
              r_state <= S_MUL_RUN;
            end else begin
              r_data  <= w_alu;
              r_state <= S_DONE;
            end
          end
        end
        S_MUL_RUN: begin
          if (w_mul_done) begin
            r_data  <= w_mul_product;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed table, hand sequences, randomized ops vs. a reference model.
module tb_alu_multicycle;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [2:0]    ALUCtrl_i;
  logic [W-1:0]  data1_i;
  logic [W-1:0]  data2_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  data_o;
  logic          zero_o;

  int n_vec  = 0;
  int n_fail = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .zero_o    (zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain arithmetic on the operation definitions.
  function automatic logic [W-1:0] ref_alu(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0] sh;
    logic [63:0] prod;
    sh = b[4:0];
    case (c)
      3'd0: return a & b;
      3'd1: return a ^ b;
      3'd2: return a << sh;
      3'd3: return a + b;
      3'd4: return a - b;
      3'd5: begin prod = 64'(a) * 64'(b); return prod[31:0]; end
      3'd6: return W'($signed(a) >>> sh);
      default: return '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] c);
    return (c == 3'd5) ? W + 1 : 1;
  endfunction

  // Holding rule: a pending result with no consumer must not change.
  always @(posedge clk_i) begin
    logic [W-1:0] held;
    if (!rst_i && valid_o && !ready_i) begin
      held = data_o;
      #1;
      check("hold_valid", {31'd0, valid_o}, 32'd1);
      check("hold_data", data_o, held);
    end
  end

  // Issue one op from IDLE with ready_i=1; junk valid_i traffic while busy must be ignored.
  task automatic run_op(input string name, input logic [2:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    int lat;
    bit busy_ok;
    ready_i = 1'b1;
    check({name, ".ready_pre"}, {31'd0, ready_o}, 32'd1);
    valid_i = 1'b1; ALUCtrl_i = c; data1_i = a; data2_i = b;
    @(posedge clk_i); #1;
    ALUCtrl_i = 3'($urandom); data1_i = $urandom; data2_i = $urandom;
    lat = 1;
    busy_ok = 1'b1;
    while (!valid_o && lat < 200) begin
      if (ready_o) busy_ok = 1'b0;
      @(posedge clk_i); #1;
      lat++;
    end
    valid_i = 1'b0;
    if (ready_o) busy_ok = 1'b0;
    check({name, ".latency"}, lat, exp_lat);
    check({name, ".busy_ready_low"}, {31'd0, busy_ok}, 32'd1);
    check({name, ".data"}, data_o, exp);
    check({name, ".zero"}, {31'd0, zero_o}, {31'd0, exp == '0});
    @(posedge clk_i); #1;
    check({name, ".idle_after"}, {30'd0, ready_o, valid_o}, 32'd2);
  endtask

  initial begin
    logic [2:0]   c;
    logic [W-1:0] a, b;
    int           cyc;
    bit           stray;

    tbl[0] = '{3'b011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1};
    tbl[1] = '{3'b100, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1};
    tbl[2] = '{3'b110, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1};
    tbl[3] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 33};
    tbl[4] = '{3'b101, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 33};
    tbl[5] = '{3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1};
    tbl[6] = '{3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1};
    tbl[7] = '{3'b010, 32'h0000_0001, 32'hFFFF_FFE1, 32'h0000_0002, 1};
    tbl[8] = '{3'b101, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33};
    tbl[9] = '{3'b110, 32'h4000_0000, 32'h0000_001E, 32'h0000_0001, 1};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    ALUCtrl_i = '0; data1_i = '0; data2_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset.valid", {31'd0, valid_o}, 32'd0);
    check("reset.ready", {31'd0, ready_o}, 32'd1);
    check("reset.data", data_o, 32'd0);
    check("reset.zero", {31'd0, zero_o}, 32'd1);
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    // Backpressure: consumer stalls five cycles while the producer keeps offering ops.
    ready_i = 1'b0;
    valid_i = 1'b1; ALUCtrl_i = 3'b001; data1_i = 32'hF0F0_F0F0; data2_i = 32'hFFFF_0000;
    @(posedge clk_i); #1;
    for (int k = 0; k < 5; k++) begin
      valid_i = k[0]; ALUCtrl_i = 3'b011; data1_i = $urandom; data2_i = $urandom;
      check($sformatf("bp.valid%0d", k), {31'd0, valid_o}, 32'd1);
      check($sformatf("bp.ready%0d", k), {31'd0, ready_o}, 32'd0);
      check($sformatf("bp.data%0d", k), data_o, 32'h0F0F_F0F0);
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    check("bp.still_valid", {31'd0, valid_o}, 32'd1);
    @(posedge clk_i); #1;
    check("bp.idle", {30'd0, ready_o, valid_o}, 32'd2);

    // Reset at cycle 10 of a MUL; the aborted op must never produce a result.
    valid_i = 1'b1; ALUCtrl_i = 3'b101; data1_i = 32'h0000_1234; data2_i = 32'h0000_5678;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (9) begin @(posedge clk_i); #1; end
    check("rstmul.busy", {31'd0, ready_o}, 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rstmul.valid", {31'd0, valid_o}, 32'd0);
    check("rstmul.ready", {31'd0, ready_o}, 32'd1);
    check("rstmul.data", data_o, 32'd0);
    check("rstmul.zero", {31'd0, zero_o}, 32'd1);
    stray = 1'b0;
    for (cyc = 0; cyc < W + 4; cyc++) begin
      @(posedge clk_i); #1;
      if (valid_o || !ready_o) stray = 1'b1;
    end
    check("rstmul.no_stray", {31'd0, stray}, 32'd0);
    run_op("rstmul.and", 3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);

    for (int i = 0; i < 150; i++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 10 == 0) b = a;
      run_op($sformatf("rnd%0d", i), c, a, b, ref_alu(c, a, b), ref_lat(c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish before 2000000");
    $fatal(1);
  end

endmodule
